imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that writes a byte-stream program image into the instruction memory's write port while holding the core stopped. It sits beside the fetch/instruction-memory path: the fetcher and decoder only read instruction memory, and this block fills it. It parses a framed stream (length, payload, checksum), packs little-endian bytes into 32-bit instructions, and issues one memory write per word. It releases the core only after a load completes with a valid checksum.

## Interface
- `ADDR_W`, default 10: word-index width of the instruction memory; capacity is 2^ADDR_W words.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE, ERROR.
- `in_valid`  in  1  a stream byte is present.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle; a transfer occurs when `in_valid && in_ready`.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_waddr`  out  ADDR_W  word index of the write.
- `imem_wdata`  out  32  instruction word, `{b3,b2,b1,b0}`.
- `cpu_hold`  out  1  when high, core chip-enable is forced off.
- `done`  out  1  level; last load succeeded.
- `err`  out  1  level; last load failed (oversize or checksum).

## Operation
- Frame format: `LEN_LO`, `LEN_HI` (N = 16-bit word count), then 4·N payload bytes (little-endian per word, word 0 first), then `CSUM`.
- CSUM is the XOR of every byte after `start`, including both length bytes and all payload bytes.
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR.
- IDLE/DONE/ERROR, when `start` is high → LEN_LO. This clears `done`, `err`, the running XOR, the byte counter and the word index, and sets `cpu_hold`=1.
- LEN_LO, on a byte transfer → LEN_HI.
- LEN_HI, on a byte transfer: N > 2^ADDR_W → ERROR; N = 0 → CSUM; otherwise → DATA.
- DATA: a 2-bit byte lane counter selects the lane. On acceptance of the lane-3 byte, the word is written (see Timing) and the word index increments. After word N-1 is written → CSUM.
- CSUM, on a byte transfer: if the byte equals the running XOR → DONE, else → ERROR.
- DONE: `done`=1, `cpu_hold`=0.
- ERROR: `err`=1, `cpu_hold`=1. Words already written stay in memory; no rollback.
- `start` while in LEN_LO..CSUM is ignored.
- `in_ready` = 1 in LEN_LO, LEN_HI, DATA, CSUM; 0 in IDLE, DONE, ERROR. Bytes offered while `in_ready`=0 are not consumed.
- Arithmetic: the word index is ADDR_W bits and never wraps, because the oversize check forbids it. The byte counter and XOR are cleared on `start`.

## Timing
- Reset values: state=IDLE, `in_ready`=0, `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0, `cpu_hold`=1, `done`=0, `err`=0.
- All outputs are registered.
- `in_ready` rises the cycle after `start` is sampled.
- Write latency: `imem_we` pulses high for exactly one cycle, in the cycle after the lane-3 byte is accepted. `imem_waddr` and `imem_wdata` are valid in that same cycle. The next byte may be accepted during the write cycle, so full throughput is 1 byte/cycle.
- `done`/`err` and the `cpu_hold` change are visible the cycle after the CSUM (or oversize LEN_HI) byte is accepted; `in_ready` drops in that same cycle.
- Gaps in `in_valid` stall the state machine with no side effects.
- `rst` mid-load: next cycle returns to IDLE with all reset values and no further writes. A write strobe pending from the reset cycle is suppressed.
- `rst` and `start` high in the same cycle: `rst` wins.

## Test plan
- Reset, then idle 5 cycles → `cpu_hold`=1, `in_ready`=0, `imem_we` never high, `done`=`err`=0.
- `start`, then bytes 01 00 93 00 10 00 82 at 1/cycle → exactly one `imem_we` pulse with waddr=0, wdata=0x00100093. Next cycle after 0x82: `done`=1, `cpu_hold`=0.
- `start`, N=2 (02 00), words 0x00100093 and 0x00208113, `in_valid` toggled every other cycle, correct CSUM → writes at waddr 0 then 1 with the matching data, then `done`=1.
- Same single-word frame with CSUM 0x83 → the word is still written, then `err`=1, `cpu_hold`=1, `done`=0.
- `ADDR_W`=4, length bytes 11 00 (N=17) → ERROR right after LEN_HI, no writes, `in_ready`=0. N=0 frame (00 00 00) → DONE with no writes.
- `rst` asserted after the 3rd payload byte → no write, IDLE, `cpu_hold`=1. A following full valid frame loads normally.

Source files
------------

// File: rtl/imem_loader.sv
// Loads a framed byte stream (length, payload, checksum) into instruction memory
// and holds the core stopped until a load completes with a matching checksum.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_waddr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  // Largest accepted word count is the full memory capacity.
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  logic [2:0]        state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       words_left_q, words_left_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       buf_q, buf_d;
  logic [7:0]        xor_q, xor_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic              in_ready_q, in_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic        xfer;
  logic [15:0] len_n;

  // in_ready_q is high exactly in the byte-consuming states.
  assign xfer  = in_valid_i && in_ready_q;
  assign len_n = {in_data_i, len_lo_q};

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    words_left_d = words_left_q;
    lane_d       = lane_q;
    buf_d        = buf_q;
    xor_d        = xor_q;
    widx_d       = widx_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    hold_d       = hold_q;
    done_d       = done_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d = S_LEN_LO;
          done_d  = 1'b0;
          err_d   = 1'b0;
          xor_d   = 8'h00;
          lane_d  = 2'd0;
          widx_d  = '0;
          hold_d  = 1'b1;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_lo_d = in_data_i;
          xor_d    = xor_q ^ in_data_i;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          xor_d = xor_q ^ in_data_i;
          if ({1'b0, len_n} > CAP) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else if (len_n == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d      = S_DATA;
            words_left_d = len_n;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          xor_d  = xor_q ^ in_data_i;
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0:    buf_d[7:0]   = in_data_i;
            2'd1:    buf_d[15:8]  = in_data_i;
            2'd2:    buf_d[23:16] = in_data_i;
            default: begin
              we_d         = 1'b1;
              waddr_d      = widx_q;
              wdata_d      = {in_data_i, buf_q};
              words_left_d = words_left_q - 16'd1;
              // At full capacity the index must not wrap past the last word.
              if (words_left_q == 16'd1) state_d = S_CSUM;
              else                       widx_d  = widx_q + 1'b1;
            end
          endcase
        end
      end
      S_CSUM: begin
        if (xfer) begin
          if (in_data_i == xor_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                 (state_d == S_DATA)   || (state_d == S_CSUM);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      len_lo_q     <= 8'h00;
      words_left_q <= 16'd0;
      lane_q       <= 2'd0;
      buf_q        <= 24'd0;
      xor_q        <= 8'h00;
      widx_q       <= '0;
      in_ready_q   <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= 32'd0;
      hold_q       <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      words_left_q <= words_left_d;
      lane_q       <= lane_d;
      buf_q        <= buf_d;
      xor_q        <= xor_d;
      widx_q       <= widx_d;
      in_ready_q   <= in_ready_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      hold_q       <= hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign in_ready_o   = in_ready_q;
  assign imem_we_o    = we_q;
  assign imem_waddr_o = waddr_q;
  assign imem_wdata_o = wdata_q;
  assign cpu_hold_o   = hold_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-size instance plus a 16-word
// instance for the capacity boundary.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic sel = 1'b0;

  logic        rdy_a, we_a, hold_a, done_a, err_a;
  logic [9:0]  waddr_a;
  logic [31:0] wdata_a;
  logic        rdy_b, we_b, hold_b, done_b, err_b;
  logic [3:0]  waddr_b;
  logic [31:0] wdata_b;
  logic        start_a, start_b, valid_a, valid_b;

  assign start_a = start & ~sel;
  assign valid_a = in_valid & ~sel;
  assign start_b = start & sel;
  assign valid_b = in_valid & sel;

  imem_loader dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .in_valid_i(valid_a),
    .in_data_i(in_data), .in_ready_o(rdy_a), .imem_we_o(we_a),
    .imem_waddr_o(waddr_a), .imem_wdata_o(wdata_a), .cpu_hold_o(hold_a),
    .done_o(done_a), .err_o(err_a)
  );

  imem_loader #(.ADDR_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .in_valid_i(valid_b),
    .in_data_i(in_data), .in_ready_o(rdy_b), .imem_we_o(we_b),
    .imem_waddr_o(waddr_b), .imem_wdata_o(wdata_b), .cpu_hold_o(hold_b),
    .done_o(done_b), .err_o(err_b)
  );

  always #5 clk = ~clk;

  // Write logs, sampled on the falling edge.
  int          wc_a = 0, wc_b = 0;
  logic [9:0]  wa_a [0:255];
  logic [31:0] wd_a [0:255];
  logic [3:0]  wa_b [0:255];
  logic [31:0] wd_b [0:255];

  always @(negedge clk) begin
    if (we_a && wc_a < 256) begin wa_a[wc_a] = waddr_a; wd_a[wc_a] = wdata_a; wc_a++; end
    if (we_b && wc_b < 256) begin wa_b[wc_b] = waddr_b; wd_b[wc_b] = wdata_b; wc_b++; end
  end

  int vectors = 0;
  int miscompares = 0;
  int base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    logic rdy;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    rdy = sel ? rdy_b : rdy_a;
    while (!rdy && n < 20) begin
      tick();
      n++;
      rdy = sel ? rdy_b : rdy_a;
    end
    if (!rdy) begin
      vectors++;
      miscompares++;
      $error("FAIL rdy_wait observed=0 expected=1 byte=%h", b);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    in_valid = 1'b0;
    tick();
    send(b);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_one_word_frame(input logic [7:0] csum);
    send(8'h01); send(8'h00);
    send(8'h93); send(8'h00); send(8'h10); send(8'h00);
    send(csum);
  endtask

  initial begin
    // Reset and idle
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("rst_hold", hold_a, 1);
    chk("rst_ready", rdy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_waddr", waddr_a, 0);
    chk("rst_wdata", wdata_a, 0);
    chk("rst_nowrite", wc_a, 0);

    // Single word, 1 byte/cycle
    pulse_start();
    chk("start_ready", rdy_a, 1);
    base = wc_a;
    send_one_word_frame(8'h82);
    chk("w1_count", wc_a - base, 1);
    chk("w1_addr", wa_a[base], 0);
    chk("w1_data", wd_a[base], 32'h00100093);
    chk("w1_done", done_a, 1);
    chk("w1_hold", hold_a, 0);
    chk("w1_err", err_a, 0);
    chk("w1_ready", rdy_a, 0);

    // Two words with gaps in in_valid
    pulse_start();
    chk("w2_done_clr", done_a, 0);
    chk("w2_hold_set", hold_a, 1);
    base = wc_a;
    send_gap(8'h02); send_gap(8'h00);
    send_gap(8'h93); send_gap(8'h00); send_gap(8'h10); send_gap(8'h00);
    send_gap(8'h13); send_gap(8'h81); send_gap(8'h20); send_gap(8'h00);
    chk("w2_not_done", done_a, 0);
    send_gap(8'h33);
    chk("w2_count", wc_a - base, 2);
    chk("w2_addr0", wa_a[base], 0);
    chk("w2_data0", wd_a[base], 32'h00100093);
    chk("w2_addr1", wa_a[base+1], 1);
    chk("w2_data1", wd_a[base+1], 32'h00208113);
    chk("w2_done", done_a, 1);

    // Bad checksum
    pulse_start();
    base = wc_a;
    send_one_word_frame(8'h83);
    chk("bad_count", wc_a - base, 1);
    chk("bad_data", wd_a[base], 32'h00100093);
    chk("bad_err", err_a, 1);
    chk("bad_hold", hold_a, 1);
    chk("bad_done", done_a, 0);
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("err_idle_ready", rdy_a, 0);
    chk("err_idle_nowrite", wc_a - base, 1);
    chk("err_idle_err", err_a, 1);

    // Small memory: oversize, empty, exactly full
    sel = 1'b1;
    pulse_start();
    send(8'h11); send(8'h00);
    chk("ovs_err", err_b, 1);
    chk("ovs_ready", rdy_b, 0);
    chk("ovs_hold", hold_b, 1);
    chk("ovs_nowrite", wc_b, 0);
    pulse_start();
    send(8'h00); send(8'h00); send(8'h00);
    chk("n0_done", done_b, 1);
    chk("n0_err", err_b, 0);
    chk("n0_nowrite", wc_b, 0);
    pulse_start();
    send(8'h10); send(8'h00);
    for (int i = 0; i < 64; i++) send(8'(i));
    send(8'h10);
    chk("full_count", wc_b, 16);
    chk("full_addr0", wa_b[0], 0);
    chk("full_data0", wd_b[0], 32'h03020100);
    chk("full_addr15", wa_b[15], 15);
    chk("full_data15", wd_b[15], 32'h3F3E3D3C);
    chk("full_done", done_b, 1);
    sel = 1'b0;

    // Reset mid-load, coinciding with the lane-3 byte
    pulse_start();
    base = wc_a;
    send(8'h01); send(8'h00);
    send(8'h93); send(8'h00); send(8'h10);
    in_valid = 1'b1; in_data = 8'h00; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    tick(); tick();
    chk("rst_mid_nowrite", wc_a - base, 0);
    chk("rst_mid_ready", rdy_a, 0);
    chk("rst_mid_hold", hold_a, 1);
    chk("rst_mid_we", we_a, 0);

    // rst and start together
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_start_ready", rdy_a, 0);

    // Full frame after reset loads normally
    pulse_start();
    base = wc_a;
    send_one_word_frame(8'h82);
    chk("post_count", wc_a - base, 1);
    chk("post_addr", wa_a[base], 0);
    chk("post_data", wd_a[base], 32'h00100093);
    chk("post_done", done_a, 1);
    chk("post_hold", hold_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
